// File: rtl/win_banner_pkg.sv
// Shared types and constants for the win-banner reader: FSM state encoding,
// bus widths, default transparent colour and the sprite address helper.
package win_banner_pkg;

    localparam int ADDR_W = 19;
    localparam int RGB_W  = 24;
    localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 24'hFF0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARMED = ST_ARMED,
        SHOW  = ST_SHOW,
        DONE  = ST_DONE
    } state_e;

    // Row-major offset into the sprite; inputs are already banner-relative.
    function automatic logic [ADDR_W-1:0] sprite_addr(
        input logic [9:0] dx,
        input logic [9:0] dy,
        input int         spr_w
    );
        logic [ADDR_W-1:0] w_row;
        w_row = ADDR_W'(dy) * ADDR_W'(spr_w);
        return w_row + ADDR_W'(dx);
    endfunction

endpackage

// File: rtl/win_banner_fetch_timer.sv
// Frame counter and blink generator for the banner display window.
// Counters restart on entry to SHOW; the banner starts in its visible phase.
module banner_frame_timer #(
    parameter int DISPLAY_FRAMES = 180,
    parameter int BLINK_FRAMES   = 15
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_start,
    input  logic i_en,
    input  logic frame_start,
    output logic o_last_frame,
    output logic o_visible
);

    localparam int FW = (DISPLAY_FRAMES > 1) ? $clog2(DISPLAY_FRAMES) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] r_frame_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_visible;
    logic          w_blink_wrap;

    assign o_last_frame = (r_frame_cnt == FW'(DISPLAY_FRAMES - 1));
    assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_FRAMES - 1));
    assign o_visible    = r_visible;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
            r_visible   <= 1'b0;
        end else if (i_start) begin
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
        end else if (i_en && frame_start) begin
            if (!o_last_frame)
                r_frame_cnt <= r_frame_cnt + 1'b1;
            // BLINK_FRAMES of zero keeps the banner steadily visible
            if (BLINK_FRAMES != 0) begin
                if (w_blink_wrap) begin
                    r_blink_cnt <= '0;
                    r_visible   <= ~r_visible;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/win_banner_fetch.sv
// Win-banner reader: sequences the display window, drives the banner ROM
// address and returns a keyed pixel three clocks after DrawX/DrawY.
module win_banner_fetch
    import win_banner_pkg::*;
#(
    parameter int               SPR_W          = 256,
    parameter int               SPR_H          = 192,
    parameter int               BANNER_X       = 192,
    parameter int               BANNER_Y       = 144,
    parameter int               DISPLAY_FRAMES = 180,
    parameter int               BLINK_FRAMES   = 15,
    parameter logic [RGB_W-1:0] KEY_COLOR      = KEY_COLOR_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              show_req,
    input  logic              winner,
    output logic [ADDR_W-1:0] read_address,
    output logic              rom_sel,
    input  logic [RGB_W-1:0]  rom_data,
    output logic [RGB_W-1:0]  pixel_rgb,
    output logic              pixel_on,
    output logic              busy,
    output logic              done
);

    state_e            r_state;
    logic              r_winner;
    logic [ADDR_W-1:0] r_read_address;
    logic              r_rom_sel;
    logic              r_v1;
    logic              r_v2;
    logic [RGB_W-1:0]  r_pixel_rgb;
    logic              r_pixel_on;

    logic              w_show_start;
    logic              w_last_frame;
    logic              w_visible;
    logic              w_in_x;
    logic              w_in_y;
    logic              w_in_region;
    logic [9:0]        w_dx;
    logic [9:0]        w_dy;
    logic [ADDR_W-1:0] w_addr;

    assign w_show_start = (r_state == ARMED) && frame_start;

    banner_frame_timer #(
        .DISPLAY_FRAMES (DISPLAY_FRAMES),
        .BLINK_FRAMES   (BLINK_FRAMES)
    ) u_timer (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_start      (w_show_start),
        .i_en         (r_state == SHOW),
        .frame_start  (frame_start),
        .o_last_frame (w_last_frame),
        .o_visible    (w_visible)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_winner <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (show_req) begin
                        r_winner <= winner;
                        r_state  <= ARMED;
                    end
                end
                ARMED:   if (frame_start) r_state <= SHOW;
                SHOW:    if (frame_start && w_last_frame) r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // 11-bit compares so a banner touching the right/bottom edge cannot wrap
    assign w_in_x = ({1'b0, DrawX} >= 11'(BANNER_X)) &&
                    ({1'b0, DrawX} <  11'(BANNER_X + SPR_W));
    assign w_in_y = ({1'b0, DrawY} >= 11'(BANNER_Y)) &&
                    ({1'b0, DrawY} <  11'(BANNER_Y + SPR_H));
    assign w_in_region = (r_state == SHOW) && w_visible && w_in_x && w_in_y;

    assign w_dx   = DrawX - 10'(BANNER_X);
    assign w_dy   = DrawY - 10'(BANNER_Y);
    assign w_addr = sprite_addr(w_dx, w_dy, SPR_W);

    // Entries already in flight drain after SHOW ends; only Reset kills them
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_read_address <= '0;
            r_rom_sel      <= 1'b0;
            r_v1           <= 1'b0;
            r_v2           <= 1'b0;
            r_pixel_rgb    <= '0;
            r_pixel_on     <= 1'b0;
        end else begin
            r_read_address <= w_in_region ? w_addr : '0;
            r_rom_sel      <= r_winner;
            r_v1           <= w_in_region;
            r_v2           <= r_v1;
            r_pixel_rgb    <= r_v2 ? rom_data : '0;
            r_pixel_on     <= r_v2 && (rom_data != KEY_COLOR);
        end
    end

    assign read_address = r_read_address;
    assign rom_sel      = r_rom_sel;
    assign pixel_rgb    = r_pixel_rgb;
    assign pixel_on     = r_pixel_on;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);

endmodule

// File: tb/tb_win_banner_fetch.sv
// Directed bench for win_banner_fetch with a short display window
// (4 frames, 2-frame blink) so whole display cycles fit in a short run.
module tb_win_banner_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        show_req;
    logic        winner;
    logic [18:0] read_address;
    logic        rom_sel;
    logic [23:0] rom_data;
    logic [23:0] pixel_rgb;
    logic        pixel_on;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    win_banner_fetch #(
        .DISPLAY_FRAMES (4),
        .BLINK_FRAMES   (2)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .show_req     (show_req),
        .winner       (winner),
        .read_address (read_address),
        .rom_sel      (rom_sel),
        .rom_data     (rom_data),
        .pixel_rgb    (pixel_rgb),
        .pixel_on     (pixel_on),
        .busy         (busy),
        .done         (done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic pulse_fs();
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic pulse_req(input logic w);
        step();
        show_req = 1'b1;
        winner   = w;
        step();
        show_req = 1'b0;
    endtask

    // Present one pixel, check the address one clock later, supply ROM data
    // for the third clock and check the keyed pixel three clocks after.
    task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [23:0] data, input logic [18:0] exp_addr,
                         input logic exp_on, input logic [23:0] exp_rgb);
        step();
        DrawX = x;
        DrawY = y;
        step();
        check({tag, " addr"}, 32'(read_address), 32'(exp_addr));
        DrawX = 10'd0;
        DrawY = 10'd0;
        step();
        rom_data = data;
        step();
        check({tag, " on"}, 32'(pixel_on), 32'(exp_on));
        check({tag, " rgb"}, 32'(pixel_rgb), 32'(exp_rgb));
        rom_data = 24'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset       = 1'b1;
        frame_start = 1'b0;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        show_req    = 1'b0;
        winner      = 1'b0;
        rom_data    = 24'h0;
        repeat (3) step();
        Reset = 1'b0;
        step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst addr", 32'(read_address), 32'd0);
        check("rst rom_sel", 32'(rom_sel), 32'd0);
        check("rst pixel_on", 32'(pixel_on), 32'd0);
        check("rst pixel_rgb", 32'(pixel_rgb), 32'd0);

        // Armed but not yet showing: nothing is fetched
        pulse_req(1'b1);
        check("armed busy", 32'(busy), 32'd1);
        probe("armed", 10'd192, 10'd144, 24'h9FF5FF, 19'd0, 1'b0, 24'h0);

        pulse_fs();
        probe("topleft", 10'd192, 10'd144, 24'h9FF5FF, 19'd0, 1'b1, 24'h9FF5FF);
        check("topleft rom_sel", 32'(rom_sel), 32'd1);
        probe("botright", 10'd447, 10'd335, 24'h123456, 19'd49151, 1'b1, 24'h123456);
        probe("right out", 10'd448, 10'd335, 24'h123456, 19'd0, 1'b0, 24'h0);
        probe("left out", 10'd191, 10'd144, 24'h123456, 19'd0, 1'b0, 24'h0);
        probe("top out", 10'd192, 10'd143, 24'h123456, 19'd0, 1'b0, 24'h0);
        probe("key", 10'd300, 10'd200, 24'hFF0000, 19'd14444, 1'b0, 24'hFF0000);

        // Re-request during SHOW must not change the winner or restart timing
        pulse_req(1'b0);
        step();
        check("req ignored rom_sel", 32'(rom_sel), 32'd1);
        check("req ignored busy", 32'(busy), 32'd1);

        pulse_fs();
        probe("frame1", 10'd200, 10'd150, 24'h00AA55, 19'd1544, 1'b1, 24'h00AA55);
        pulse_fs();
        probe("frame2 hidden", 10'd200, 10'd150, 24'h00AA55, 19'd0, 1'b0, 24'h0);
        pulse_fs();
        probe("frame3 hidden", 10'd200, 10'd150, 24'h00AA55, 19'd0, 1'b0, 24'h0);
        check("frame3 done", 32'(done), 32'd0);
        check("frame3 busy", 32'(busy), 32'd1);
        pulse_fs();
        check("end done", 32'(done), 32'd1);
        step();
        check("end done clear", 32'(done), 32'd0);
        check("end busy", 32'(busy), 32'd0);
        pulse_fs();
        check("idle fs busy", 32'(busy), 32'd0);

        // Request and frame boundary together only arm
        step();
        show_req    = 1'b1;
        winner      = 1'b0;
        frame_start = 1'b1;
        step();
        show_req    = 1'b0;
        frame_start = 1'b0;
        check("same cycle busy", 32'(busy), 32'd1);
        probe("same cycle armed", 10'd192, 10'd144, 24'h9FF5FF, 19'd0, 1'b0, 24'h0);
        pulse_fs();
        probe("p1 show", 10'd193, 10'd145, 24'h0000FF, 19'd257, 1'b1, 24'h0000FF);
        check("p1 rom_sel", 32'(rom_sel), 32'd0);

        // Reset while an opaque pixel is on screen
        step();
        DrawX    = 10'd200;
        DrawY    = 10'd150;
        rom_data = 24'h9FF5FF;
        repeat (3) step();
        check("pre-reset pixel_on", 32'(pixel_on), 32'd1);
        check("pre-reset addr", 32'(read_address), 32'd1544);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset pixel_on", 32'(pixel_on), 32'd0);
        check("mid reset addr", 32'(read_address), 32'd0);
        pulse_fs();
        step();
        check("post reset fs busy", 32'(busy), 32'd0);
        check("post reset pixel_on", 32'(pixel_on), 32'd0);
        check("post reset addr", 32'(read_address), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/win_banner_fetch.md
Name: win_banner_fetch

Overview:
- Reader side of the palette-indexed sprite ROMs (Player1/Player2 win banners): one registered read address in, 24-bit RGB out one Clk later.
- On an end-of-game request, waits for a frame boundary, then for DISPLAY_FRAMES frames generates ROM addresses from the VGA DrawX/DrawY, realigns the ROM latency and emits a keyed RGB pixel plus pixel_on to the colour mapper.
- Sits between the VGA controller, the game FSM and the two banner ROMs.

Parameters:
- SPR_W, 256, banner width in pixels
- SPR_H, 192, banner height in pixels (SPR_W*SPR_H ≤ 2^19)
- BANNER_X, 192, screen X of banner top-left
- BANNER_Y, 144, screen Y of banner top-left
- DISPLAY_FRAMES, 180, frames the banner stays up
- BLINK_FRAMES, 15, visible/hidden half-period in frames; 0 = steady
- KEY_COLOR, 24'hFF0000, transparent palette colour

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse at start of vertical blank
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- show_req  in  1  one-cycle request to display a banner
- winner  in  1  0 = Player1 banner, 1 = Player2 banner; sampled with show_req
- read_address  out  19  address to both banner ROMs
- rom_sel  out  1  selects which ROM data_Out feeds rom_data
- rom_data  in  24  selected ROM data_Out (valid 1 Clk after read_address)
- pixel_rgb  out  24  banner colour
- pixel_on  out  1  banner pixel is opaque and visible
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when display ends

Behaviour:
- Interface: one clock Clk; Reset synchronous, active-high.
- Reset (any time, incl. mid-display): state=IDLE; read_address=0, rom_sel=0, pixel_rgb=0, pixel_on=0, busy=0, done=0; frame and blink counters=0; all pipeline valid flags cleared.
- FSM: IDLE -> ARMED on show_req (latch winner). ARMED -> SHOW on frame_start. SHOW -> DONE when frame counter reaches DISPLAY_FRAMES-1 and frame_start arrives. DONE -> IDLE after exactly one cycle; done=1 only in DONE.
- show_req outside IDLE is ignored; winner is not re-sampled.
- show_req and frame_start in the same IDLE cycle: go to ARMED only; display starts on the following frame_start.
- Frame counter increments on frame_start in SHOW. Blink counter wraps at BLINK_FRAMES-1 and toggles the visible flag; the visible flag is 1 on entry to SHOW.
- Pipeline, with t = cycle DrawX/DrawY are presented:
  - t: in_region = SHOW && visible && BANNER_X ≤ DrawX < BANNER_X+SPR_W && BANNER_Y ≤ DrawY < BANNER_Y+SPR_H.
  - t+1: read_address = (DrawY-BANNER_Y)*SPR_W + (DrawX-BANNER_X) if in_region, else 0; rom_sel = latched winner; v1 = in_region.
  - t+2: ROM output is valid.
  - t+3: pixel_rgb = rom_data; pixel_on = v2 && (rom_data != KEY_COLOR).
  - Fixed latency 3; the top level delays DrawX/DrawY consumers to match.
- Outside the region or outside SHOW: pixel_on=0 and pixel_rgb=0.
- Width rules: subtractions are 10-bit and are used only when in_region, so there is no wrap. Address is computed at 19 bits, unsigned.
- Leaving SHOW mid-line: already-issued pipeline entries drain. pixel_on may stay high for ≤2 cycles after the state change. Reset cancels them immediately.

Decomposition:
- Package win_banner_pkg: FSM state enum (IDLE, ARMED, SHOW, DONE), ADDR_W=19, RGB_W=24, default KEY_COLOR.
- One sub-module, banner_frame_timer: frame counter, blink counter and visible flag, driven by frame_start and a SHOW enable.
- Address/pixel pipeline and FSM stay in the top.

Test Plan:
- Reset mid-SHOW (pixel_on=1): next cycle busy=0, pixel_on=0, read_address=0. A frame_start afterwards does not restart the display.
- show_req with winner=1, then frame_start, then DrawX=192, DrawY=144: read_address=0 and rom_sel=1 at t+1. With rom_data=24'h9FF5FF at t+2, pixel_rgb=24'h9FF5FF and pixel_on=1 at t+3.
- DrawX=447, DrawY=335 in SHOW -> read_address=49151. DrawX=448 -> pixel_on=0 at t+3.
- rom_data=24'hFF0000 inside the region -> pixel_on=0 at t+3.
- DISPLAY_FRAMES=4, BLINK_FRAMES=2, full-screen sweep per frame: frames 0-1 visible, frames 2-3 hidden; done pulses one cycle after the 4th frame_start in SHOW; busy=0 afterwards.
- show_req during SHOW with a different winner -> ignored; rom_sel and frame count unchanged.
